// File: rtl/collision_detector.sv
// Pixel collision decoder with per-frame hit latches, boss health and player-life FSM.
// Define COLLISION_INVULN_EN to add a post-hit invulnerability window of INVULN_FRAMES frames.
module collision_detector #(
    parameter int BOSS_HITS     = 10,
    parameter int PLAYER_LIVES  = 3,
    parameter int INVULN_FRAMES = 60
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       enable,
    input  logic       playerDR,
    input  logic       playerMissileDR,
    input  logic       bossDR,
    input  logic       bossMissileDR,
    input  logic       chickenDR,
    input  logic       borderDR,
    output logic [6:0] collision,
    output logic       playerHit,
    output logic [7:0] bossHealth,
    output logic [3:0] livesLeft,
    output logic       bossDefeated,
    output logic       gameOver
);

    typedef enum logic [1:0] {
        ALIVE  = 2'd0,
        INVULN = 2'd1,
        DEAD   = 2'd2
    } player_state_t;

    generate
        if (BOSS_HITS < 1 || BOSS_HITS > 255 || PLAYER_LIVES < 1 || PLAYER_LIVES > 15 ||
            INVULN_FRAMES < 1 || INVULN_FRAMES > 255) begin : g_bad_params
            $error("collision_detector: parameter out of range");
        end
    endgenerate

    player_state_t state_reg;
    logic          boss_latch_reg;
    logic          player_latch_reg;
    logic          frame_eval;
    logic          boss_pixel;
    logic          player_pixel;

`ifdef COLLISION_INVULN_EN
    localparam logic [7:0] INVULN_LAST = 8'(INVULN_FRAMES - 1);
    logic [7:0] invuln_cnt_reg;
`endif

    always_comb begin
        collision    = 7'd0;
        collision[0] = playerMissileDR & (bossDR | chickenDR);
        collision[1] = borderDR & (playerDR | bossDR | chickenDR | playerMissileDR | bossMissileDR);
        collision[2] = bossMissileDR & playerDR;
        collision[3] = playerDR & (bossDR | chickenDR);
        collision[4] = bossMissileDR & borderDR;
        collision[5] = playerMissileDR & chickenDR;
        collision[6] = bossMissileDR & playerMissileDR;
    end

    assign frame_eval   = startOfFrame & enable;
    assign boss_pixel   = collision[0] & bossDR;
    assign player_pixel = collision[2] | collision[3];

    always_ff @(posedge clk) begin
        if (resetN) begin
            state_reg        <= ALIVE;
            boss_latch_reg   <= 1'b0;
            player_latch_reg <= 1'b0;
            playerHit        <= 1'b0;
            bossHealth       <= 8'(BOSS_HITS);
            livesLeft        <= 4'(PLAYER_LIVES);
            bossDefeated     <= 1'b0;
            gameOver         <= 1'b0;
`ifdef COLLISION_INVULN_EN
            invuln_cnt_reg   <= 8'd0;
`endif
        end else begin
            playerHit    <= 1'b0;
            bossDefeated <= bossDefeated | (bossHealth == 8'd0);
            if (frame_eval) begin
                // Old frame is judged from the latches; this cycle's pixel seeds the new frame.
                boss_latch_reg   <= boss_pixel;
                player_latch_reg <= player_pixel;
                if (boss_latch_reg && !gameOver && bossHealth != 8'd0)
                    bossHealth <= bossHealth - 8'd1;
                case (state_reg)
                    ALIVE: begin
                        if (player_latch_reg && !bossDefeated) begin
                            playerHit <= 1'b1;
                            livesLeft <= livesLeft - 4'd1;
                            if (livesLeft == 4'd1) begin
                                state_reg <= DEAD;
                                gameOver  <= 1'b1;
                            end else begin
`ifdef COLLISION_INVULN_EN
                                state_reg      <= INVULN;
                                invuln_cnt_reg <= 8'd0;
`else
                                state_reg      <= ALIVE;
`endif
                            end
                        end
                    end
                    INVULN: begin
`ifdef COLLISION_INVULN_EN
                        if (invuln_cnt_reg == INVULN_LAST) begin
                            state_reg      <= ALIVE;
                            invuln_cnt_reg <= 8'd0;
                        end else begin
                            invuln_cnt_reg <= invuln_cnt_reg + 8'd1;
                        end
`else
                        state_reg <= ALIVE;
`endif
                    end
                    DEAD:    gameOver  <= 1'b1;
                    default: state_reg <= ALIVE;
                endcase
            end else begin
                boss_latch_reg   <= boss_latch_reg | boss_pixel;
                player_latch_reg <= player_latch_reg | player_pixel;
            end
        end
    end

endmodule

// File: tb/tb_collision_detector.sv
// Directed-vector bench for collision_detector with a frame-level reference model
// and a per-cycle compare process; honours COLLISION_INVULN_EN like the design.
module tb_collision_detector;

    localparam int BOSS  = 10;
    localparam int LIVES = 3;
    localparam int INV   = 4;

    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] P    = 6'b100000;
    localparam logic [5:0] PM   = 6'b010000;
    localparam logic [5:0] B    = 6'b001000;

    logic       clk = 1'b0;
    logic       resetN, startOfFrame, enable;
    logic       playerDR, playerMissileDR, bossDR, bossMissileDR, chickenDR, borderDR;
    logic [6:0] collision;
    logic       playerHit;
    logic [7:0] bossHealth;
    logic [3:0] livesLeft;
    logic       bossDefeated, gameOver;

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    // reference model state (frame level)
    int m_bh, m_lives, m_inv_left;
    bit m_bl, m_pl, m_ph, m_def, m_go;

    collision_detector #(
        .BOSS_HITS(BOSS), .PLAYER_LIVES(LIVES), .INVULN_FRAMES(INV)
    ) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .enable(enable),
        .playerDR(playerDR), .playerMissileDR(playerMissileDR), .bossDR(bossDR),
        .bossMissileDR(bossMissileDR), .chickenDR(chickenDR), .borderDR(borderDR),
        .collision(collision), .playerHit(playerHit), .bossHealth(bossHealth),
        .livesLeft(livesLeft), .bossDefeated(bossDefeated), .gameOver(gameOver)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] exp_coll(input logic p, pm, b, bm, c, bd);
        logic [6:0] r;
        r[0] = pm & (b | c);
        r[1] = bd & (p | b | c | pm | bm);
        r[2] = bm & p;
        r[3] = p & (b | c);
        r[4] = bm & bd;
        r[5] = pm & c;
        r[6] = bm & pm;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Model: what each frame boundary must do, in terms of health, lives and frames of grace.
    always @(posedge clk) begin
        bit hit_b, hit_p, def_new;
        hit_b = playerMissileDR && bossDR;
        hit_p = playerDR && (bossMissileDR || bossDR || chickenDR);
        if (resetN) begin
            m_bh = BOSS; m_lives = LIVES; m_inv_left = 0;
            m_bl = 0; m_pl = 0; m_ph = 0; m_def = 0; m_go = 0;
        end else begin
            def_new = m_def || (m_bh == 0);
            m_ph = 0;
            if (startOfFrame && enable) begin
                if (m_bl && !m_go && m_bh > 0) m_bh = m_bh - 1;
                if (m_go) begin
                end else if (m_inv_left > 0) begin
                    m_inv_left = m_inv_left - 1;
                end else if (m_pl && !m_def) begin
                    m_ph = 1;
                    m_lives = m_lives - 1;
                    if (m_lives == 0) m_go = 1;
`ifdef COLLISION_INVULN_EN
                    else m_inv_left = INV;
`endif
                end
                m_bl = hit_b;
                m_pl = hit_p;
            end else begin
                m_bl = m_bl || hit_b;
                m_pl = m_pl || hit_p;
            end
            m_def = def_new;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("collision", collision, exp_coll(playerDR, playerMissileDR, bossDR,
                                                   bossMissileDR, chickenDR, borderDR));
            check("playerHit", playerHit, m_ph);
            check("bossHealth", bossHealth, m_bh);
            check("livesLeft", livesLeft, m_lives);
            check("bossDefeated", bossDefeated, m_def);
            check("gameOver", gameOver, m_go);
        end
    end

    // One clock cycle with the given inputs held across the rising edge.
    task automatic drv(input logic s, input logic e, input logic r, input logic [5:0] d);
        {playerDR, playerMissileDR, bossDR, bossMissileDR, chickenDR, borderDR} = d;
        startOfFrame = s;
        enable = e;
        resetN = r;
        @(posedge clk);
        #2;
    endtask

    task automatic frame(input logic [5:0] d, input int n);
        for (int i = 0; i < n; i++) drv(1'b0, 1'b1, 1'b0, d);
        drv(1'b1, 1'b1, 1'b0, NONE);
    endtask

    initial begin
        drv(1'b0, 1'b0, 1'b1, NONE);
        chk_on = 1'b1;
        drv(1'b0, 1'b0, 1'b1, NONE);
        $display("[TB] reset");
        check("rst_bossHealth", bossHealth, 10);
        check("rst_livesLeft", livesLeft, 3);
        check("rst_flags", {playerHit, bossDefeated, gameOver}, 0);

        drv(1'b0, 1'b1, 1'b0, PM | B);
        $display("[TB] collision sweep");
        check("coll_pm_boss", collision, 7'b0000001);
        for (int i = 0; i < 64; i++) drv(1'b0, 1'b1, 1'b0, 6'(i));
        drv(1'b0, 1'b1, 1'b1, NONE);

        $display("[TB] boss hit on 3 pixels");
        frame(PM | B, 3);
        check("boss_once", bossHealth, 9);
        frame(NONE, 2);
        check("boss_cleared", bossHealth, 9);

        $display("[TB] hit on the startOfFrame cycle");
        drv(1'b1, 1'b1, 1'b0, PM | B);
        check("sof_hit_next", bossHealth, 9);
        frame(NONE, 2);
        check("sof_hit_new_frame", bossHealth, 8);

        $display("[TB] reset discards pending hits");
        drv(1'b0, 1'b1, 1'b0, PM | B);
        drv(1'b0, 1'b1, 1'b0, P | B);
        drv(1'b0, 1'b1, 1'b1, NONE);
        frame(NONE, 2);
        check("pend_boss", bossHealth, 10);
        check("pend_lives", livesLeft, 3);

        $display("[TB] player hit frames 1..6");
        frame(P | B, 2);
        check("p1_pulse", playerHit, 1);
        check("p1_lives", livesLeft, 2);
        for (int k = 2; k <= 6; k++) frame(P | B, 2);
`ifdef COLLISION_INVULN_EN
        check("p6_pulse", playerHit, 1);
        check("p6_lives", livesLeft, 1);
`else
        check("p6_lives", livesLeft, 0);
        check("p6_gameover", gameOver, 1);
`endif
        frame(PM | B, 2);
        frame(PM | B, 2);

        $display("[TB] enable low over two frame pulses");
        drv(1'b0, 1'b1, 1'b1, NONE);
        drv(1'b0, 1'b0, 1'b0, PM | B);
        drv(1'b1, 1'b0, 1'b0, NONE);
        drv(1'b0, 1'b0, 1'b0, PM | B);
        drv(1'b1, 1'b0, 1'b0, NONE);
        check("en_hold", bossHealth, 10);
        drv(1'b1, 1'b1, 1'b0, NONE);
        check("en_one_dec", bossHealth, 9);
        frame(NONE, 1);
        check("en_no_second", bossHealth, 9);
        drv(1'b0, 1'b1, 1'b0, PM | B | P);
        drv(1'b1, 1'b1, 1'b1, NONE);
        check("rst_sof_boss", bossHealth, 10);
        check("rst_sof_lives", livesLeft, 3);
        check("rst_sof_flags", {playerHit, bossDefeated, gameOver}, 0);

        $display("[TB] boss defeat");
        for (int k = 0; k < 10; k++) frame(PM | B, 1);
        check("defeat_health", bossHealth, 0);
        check("defeat_delay", bossDefeated, 0);
        drv(1'b0, 1'b1, 1'b0, NONE);
        check("defeat_set", bossDefeated, 1);
        frame(P | B, 2);
        check("defeat_no_pulse", playerHit, 0);
        check("defeat_lives", livesLeft, 3);
        frame(PM | B, 2);
        check("defeat_sat", bossHealth, 0);

        $display("[TB] game over freezes boss health");
        drv(1'b0, 1'b1, 1'b1, NONE);
        for (int k = 0; k < 14; k++) frame(P | PM | B, 2);
        frame(NONE, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
